// File: rtl/debounced_counter_pkg.sv
// Shared definitions for the debounced up/down counter: channel indices,
// channel count and the debounce-counter width helper.
package debounced_counter_pkg;

    typedef enum logic [1:0] {
        CH_UP  = 2'd0,
        CH_DN  = 2'd1,
        CH_CLR = 2'd2
    } ch_e;

    localparam int N_CH = 3;

    // Width needed to count 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/debounce_sync.sv
// One button channel: synchronizer, stable-time debouncer and press pulse.
// The stable level is reported as 1 = pressed regardless of PRESS_LEVEL.
module debounce_sync
    import debounced_counter_pkg::*;
#(
    parameter int   DB_CYCLES   = 1000,
    parameter int   SYNC_STAGES = 2,
    parameter logic PRESS_LEVEL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic stable,
    output logic press
);

    localparam int            CW     = cnt_width(DB_CYCLES);
    localparam logic [CW-1:0] C_LAST = CW'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_p0;
    logic [CW-1:0]          db_cnt_p1;
    logic                   stable_p1;
    logic                   press_p1;
    logic                   pressed_s;

    assign pressed_s = (sync_p0[SYNC_STAGES-1] == PRESS_LEVEL);

    // Stage 0: synchronizer chain, reset to the released level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= {SYNC_STAGES{~PRESS_LEVEL}};
        end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], btn};
        end
    end

    // Stage 1: any cycle back at the old level restarts the qualification count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt_p1 <= '0;
            stable_p1 <= 1'b0;
            press_p1  <= 1'b0;
        end else begin
            press_p1 <= 1'b0;
            if (pressed_s == stable_p1) begin
                db_cnt_p1 <= '0;
            end else if (db_cnt_p1 == C_LAST) begin
                db_cnt_p1 <= '0;
                stable_p1 <= pressed_s;
                press_p1  <= pressed_s;
            end else begin
                db_cnt_p1 <= db_cnt_p1 + 1'b1;
            end
        end
    end

    assign stable = stable_p1;
    assign press  = press_p1;

endmodule

// File: rtl/debounced_updown_counter.sv
// Three-button up/down/clear counter driven by debounced press events,
// with selectable wrap or saturate behaviour at the range limits.
module debounced_updown_counter
    import debounced_counter_pkg::*;
#(
    parameter int   CNT_W       = 8,
    parameter int   DB_CYCLES   = 1000,
    parameter int   SYNC_STAGES = 2,
    parameter logic PRESS_LEVEL = 1'b1,
    parameter bit   SATURATE    = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_up,
    input  logic             btn_dn,
    input  logic             btn_clr,
    output logic [CNT_W-1:0] cnt,
    output logic [2:0]       btn_stable,
    output logic [2:0]       press_evt,
    output logic             limit
);

    logic [N_CH-1:0]  btn_raw;
    logic [CNT_W-1:0] cnt_p2;
    logic             limit_p2;

    assign btn_raw = {btn_clr, btn_dn, btn_up};

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_sync #(
            .DB_CYCLES  (DB_CYCLES),
            .SYNC_STAGES(SYNC_STAGES),
            .PRESS_LEVEL(PRESS_LEVEL)
        ) u_db (
            .clk   (clk),
            .rst_n (rst_n),
            .btn   (btn_raw[i]),
            .stable(btn_stable[i]),
            .press (press_evt[i])
        );
    end

    // Returns {limit, next count}; clear beats everything, up+dn cancel.
    function automatic logic [CNT_W:0] count_step(input logic [CNT_W-1:0] c,
                                                  input logic [N_CH-1:0]  evt);
        logic [CNT_W:0] r;
        r = {1'b0, c};
        if (evt[CH_CLR]) begin
            r = '0;
        end else if (evt[CH_UP] && evt[CH_DN]) begin
            r = {1'b0, c};
        end else if (evt[CH_UP]) begin
            if (c == {CNT_W{1'b1}}) r = {1'b1, (SATURATE ? c : {CNT_W{1'b0}})};
            else                    r = {1'b0, c + 1'b1};
        end else if (evt[CH_DN]) begin
            if (c == {CNT_W{1'b0}}) r = {1'b1, (SATURATE ? c : {CNT_W{1'b1}})};
            else                    r = {1'b0, c - 1'b1};
        end
        return r;
    endfunction

    // Stage 2: counter and limit pulse, one edge after the press events
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_p2   <= '0;
            limit_p2 <= 1'b0;
        end else begin
            {limit_p2, cnt_p2} <= count_step(cnt_p2, press_evt);
        end
    end

    assign cnt   = cnt_p2;
    assign limit = limit_p2;

endmodule

// File: tb/tb_debounced_updown_counter.sv
// Directed bench: a wrapping and a saturating counter share the same buttons.
module tb_debounced_updown_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_up, btn_dn, btn_clr;
    logic [7:0] cnt_w, cnt_s;
    logic [2:0] stb_w, stb_s, evt_w, evt_s;
    logic       lim_w, lim_s;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    debounced_updown_counter #(
        .CNT_W(8), .DB_CYCLES(16), .SYNC_STAGES(2), .PRESS_LEVEL(1'b1), .SATURATE(1'b0)
    ) dut_w (
        .clk(clk), .rst_n(rst_n), .btn_up(btn_up), .btn_dn(btn_dn), .btn_clr(btn_clr),
        .cnt(cnt_w), .btn_stable(stb_w), .press_evt(evt_w), .limit(lim_w)
    );

    debounced_updown_counter #(
        .CNT_W(8), .DB_CYCLES(16), .SYNC_STAGES(2), .PRESS_LEVEL(1'b1), .SATURATE(1'b1)
    ) dut_s (
        .clk(clk), .rst_n(rst_n), .btn_up(btn_up), .btn_dn(btn_dn), .btn_clr(btn_clr),
        .cnt(cnt_s), .btn_stable(stb_s), .press_evt(evt_s), .limit(lim_s)
    );

    typedef struct {
        logic       u, d, c;
        logic [7:0] w;
        logic       wl;
        logic [7:0] s;
        logic       sl;
    } vec_t;

    vec_t tbl[17];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Press the given buttons, hold, release; optionally check timing and results.
    task automatic press(input logic u, input logic d, input logic c, input bit chk,
                         input logic [7:0] ew, input logic ewl,
                         input logic [7:0] es, input logic esl);
        logic [2:0] b;
        b = {c, d, u};
        @(negedge clk);
        {btn_clr, btn_dn, btn_up} = b;
        repeat (17) @(posedge clk);
        #1;
        if (chk) check("evt_early", {29'd0, evt_w | evt_s}, 32'd0);
        @(posedge clk);
        #1;
        if (chk) begin
            check("evt_w", {29'd0, evt_w}, {29'd0, b});
            check("evt_s", {29'd0, evt_s}, {29'd0, b});
            check("stb_w", {29'd0, stb_w}, {29'd0, b});
        end
        @(posedge clk);
        #1;
        if (chk) begin
            check("cnt_w", {24'd0, cnt_w}, {24'd0, ew});
            check("lim_w", {31'd0, lim_w}, {31'd0, ewl});
            check("cnt_s", {24'd0, cnt_s}, {24'd0, es});
            check("lim_s", {31'd0, lim_s}, {31'd0, esl});
            check("evt_pulse", {29'd0, evt_w | evt_s}, 32'd0);
        end
        @(posedge clk);
        #1;
        if (chk) check("lim_pulse", {30'd0, lim_w, lim_s}, 32'd0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        {btn_clr, btn_dn, btn_up} = 3'b000;
        repeat (22) @(posedge clk);
        #1;
        if (chk) check("stb_release", {26'd0, stb_w, stb_s}, 32'd0);
    endtask

    initial begin
        int n_ev;
        int bad;

        tbl[0]  = '{0,0,1,   8'd0,0,   8'd0,0};
        tbl[1]  = '{1,0,0,   8'd1,0,   8'd1,0};
        tbl[2]  = '{1,0,0,   8'd2,0,   8'd2,0};
        tbl[3]  = '{1,0,0,   8'd3,0,   8'd3,0};
        tbl[4]  = '{0,1,0,   8'd2,0,   8'd2,0};
        tbl[5]  = '{0,1,0,   8'd1,0,   8'd1,0};
        tbl[6]  = '{0,1,0,   8'd0,0,   8'd0,0};
        tbl[7]  = '{0,1,0, 8'd255,1,   8'd0,1};
        tbl[8]  = '{1,1,0, 8'd255,0,   8'd0,0};
        tbl[9]  = '{1,0,0,   8'd0,1,   8'd1,0};
        tbl[10] = '{1,0,0,   8'd1,0,   8'd2,0};
        tbl[11] = '{1,0,0,   8'd2,0,   8'd3,0};
        tbl[12] = '{1,0,0,   8'd3,0,   8'd4,0};
        tbl[13] = '{1,0,0,   8'd4,0,   8'd5,0};
        tbl[14] = '{1,0,1,   8'd0,0,   8'd0,0};
        tbl[15] = '{0,1,1,   8'd0,0,   8'd0,0};
        tbl[16] = '{0,1,0, 8'd255,1,   8'd0,1};

        rst_n = 1'b0;
        {btn_clr, btn_dn, btn_up} = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cnt", {16'd0, cnt_w, cnt_s}, 32'd0);
        check("rst_flags", {24'd0, stb_w, evt_w, lim_w, lim_s}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // Bouncy press: 1/0/1/0 single cycles, then held
        @(negedge clk); btn_up = 1'b1;
        @(negedge clk); btn_up = 1'b0;
        @(negedge clk); btn_up = 1'b1;
        @(negedge clk); btn_up = 1'b0;
        @(negedge clk); btn_up = 1'b1;
        n_ev = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (evt_w[0]) n_ev++;
            if (k == 17) check("bounce_evt_early", {31'd0, evt_w[0]}, 32'd0);
            if (k == 18) check("bounce_evt", {31'd0, evt_w[0]}, 32'd1);
            if (k == 19) check("bounce_cnt", {16'd0, cnt_w, cnt_s}, {16'd0, 8'd1, 8'd1});
            if (k == 40) check("bounce_held_stb", {31'd0, stb_w[0]}, 32'd1);
        end
        @(negedge clk);
        btn_up = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            @(posedge clk);
            #1;
            if (evt_w[0]) n_ev++;
            if (k == 17) check("release_stb_held", {31'd0, stb_w[0]}, 32'd1);
            if (k == 18) check("release_stb", {31'd0, stb_w[0]}, 32'd0);
        end
        check("bounce_one_event", n_ev, 32'd1);

        // Pulses one cycle short of qualifying never reach the outputs
        bad = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            btn_up = ((k % 30) < 15);
            @(posedge clk);
            #1;
            if (evt_w != 3'b000 || stb_w != 3'b000) bad++;
        end
        @(negedge clk);
        btn_up = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("short_pulse_quiet", bad, 32'd0);
        check("short_pulse_cnt", {16'd0, cnt_w, cnt_s}, {16'd0, 8'd1, 8'd1});
        @(negedge clk);
        btn_up = 1'b1;
        repeat (16) @(negedge clk);
        btn_up = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("min_pulse_cnt", {16'd0, cnt_w, cnt_s}, {16'd0, 8'd2, 8'd2});

        for (int i = 0; i < 17; i++)
            press(tbl[i].u, tbl[i].d, tbl[i].c, 1'b1, tbl[i].w, tbl[i].wl, tbl[i].s, tbl[i].sl);

        // Reset in the middle of qualification with the button still held
        @(negedge clk);
        btn_up = 1'b1;
        repeat (12) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_cnt", {16'd0, cnt_w, cnt_s}, 32'd0);
        check("midrst_flags", {24'd0, stb_w, evt_w, lim_w, lim_s}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            @(posedge clk);
            #1;
            if (k == 17) check("requal_early", {29'd0, evt_w | stb_w}, 32'd0);
            if (k == 18) check("requal_evt", {29'd0, evt_w}, 32'd1);
            if (k == 19) check("requal_cnt", {16'd0, cnt_w, cnt_s}, {16'd0, 8'd1, 8'd1});
        end
        @(negedge clk);
        btn_up = 1'b0;
        repeat (25) @(posedge clk);

        // Climb to the top, then one more up at max
        for (int i = 0; i < 254; i++)
            press(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
        #1;
        check("top_cnt", {16'd0, cnt_w, cnt_s}, {16'd0, 8'd255, 8'd255});
        press(1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 1'b1, 8'd255, 1'b1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
